// File: rtl/uart_pkg.sv
`default_nettype none
// ==========================================================================
// uart_pkg : UART frame constants, TX state type and baud divisor helper.
// Revision : 1.0 - initial release
// ==========================================================================
package uart_pkg;

   localparam int   DATA_BITS = 8;
   localparam logic LINE_IDLE = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   function automatic int baud_tick(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ==========================================================================
// uart_baud_gen : free-running bit-period counter with synchronous clear.
// Revision      : 1.0 - initial release
// ==========================================================================
module uart_baud_gen #(
   parameter int BAUD_TICK = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic bit_end
);

   localparam int             CW   = $clog2(BAUD_TICK);
   localparam logic [CW-1:0]  LAST = CW'(BAUD_TICK - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign bit_end = (count == LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ==========================================================================
// uart_tx  : UART transmitter, 8N1/8E1/8O1/8x2 frames, one-byte holding reg.
// Revision : 1.0 - initial release
// ==========================================================================
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       tx,
   output logic       busy,
   output logic       tx_done
);

   localparam int        BAUD_TICK  = baud_tick(CLK_FREQ, BAUD_RATE);
   localparam tx_state_t AFTER_DATA = (PARITY_EN != 0) ? PARITY : STOP;
   localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
   localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
   localparam logic       ODD       = (PARITY_ODD != 0);

   tx_state_t  state;
   logic [7:0] hold_data;
   logic       hold_full;
   logic [7:0] shift;
   logic [2:0] bit_idx;
   logic       bit_end;
   logic       baud_clear;
   logic       line_bit;

   // Counter is held at zero while idle so every frame starts on a fresh bit period.
   assign baud_clear = (state == IDLE);

   uart_baud_gen #(
      .BAUD_TICK (BAUD_TICK)
   ) u_baud (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (baud_clear),
      .bit_end (bit_end)
   );

   always_comb begin
      line_bit = LINE_IDLE;
      case (state)
         START:   line_bit = 1'b0;
         DATA:    line_bit = shift[bit_idx];
         PARITY:  line_bit = (^shift) ^ ODD;
         default: line_bit = LINE_IDLE;
      endcase
   end

   assign in_ready = !hold_full;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         hold_data <= '0;
         hold_full <= 1'b0;
         shift     <= '0;
         bit_idx   <= '0;
         tx        <= LINE_IDLE;
         busy      <= 1'b0;
         tx_done   <= 1'b0;
      end else begin
         // Outputs trail the state by one clock, so tx, busy and tx_done stay aligned.
         tx      <= line_bit;
         busy    <= (state != IDLE);
         tx_done <= 1'b0;

         if (in_valid && !hold_full) begin
            hold_data <= in_data;
            hold_full <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (hold_full) begin
                  shift     <= hold_data;
                  hold_full <= 1'b0;
                  bit_idx   <= '0;
                  state     <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  bit_idx <= '0;
                  state   <= DATA;
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_idx == LAST_DATA) begin
                     bit_idx <= '0;
                     state   <= AFTER_DATA;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
            end
            PARITY: begin
               if (bit_end) begin
                  bit_idx <= '0;
                  state   <= STOP;
               end
            end
            STOP: begin
               if (bit_end) begin
                  if (bit_idx == LAST_STOP) begin
                     tx_done <= 1'b1;
                     bit_idx <= '0;
                     if (hold_full) begin
                        shift     <= hold_data;
                        hold_full <= 1'b0;
                        state     <= START;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
